mips32r2_tlb_probe_engine: RTL and testbench
============================================

Name: mips32r2_tlb_probe_engine

Overview:
- Main (backing) joint TLB array plus a group-serial lookup engine.
- Services refill probes from the fast TLB cache (mips32r2_fasttlb p_* port): scans GROUP_SIZE entries per cycle and returns the matching entry and its index.
- Also owns the TLBWI/TLBWR write port and the TLBR read port used by CP0.

Parameters:
- ENTRIES, 64, number of joint TLB entries (power of 2).
- GROUP_SIZE, 4, entries compared per scan cycle (power of 2, divides ENTRIES).
- NGROUPS (derived), ENTRIES/GROUP_SIZE, scan cycles for a full sweep.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- p_valid  in  1  probe request active (tied to fast-TLB q_valid).
- p_ivpn2  in  19  probe VPN2 (vaddr[31:13]).
- p_iasid  in  8  probe ASID.
- p_ready  out  1  one-cycle pulse: match found this cycle.
- p_index  out  $clog2(ENTRIES)  index of the matching entry; valid with p_ready.
- p_resp  out  $bits(TLBEntry)  matching entry contents; valid with p_ready.
- w_valid  in  1  write strobe (TLBWI/TLBWR); same signal also drives fast-TLB w_valid.
- w_index  in  $clog2(ENTRIES)  write index.
- w_entry  in  $bits(TLBEntry)  entry to write.
- r_index  in  $clog2(ENTRIES)  TLBR read index.
- r_entry  out  $bits(TLBEntry)  combinational read of the array at r_index, including same-cycle write data if w_index==r_index is not required; returns the pre-write value.

Behaviour:
- Storage: ENTRIES x TLBEntry array plus a per-entry written bit.
  - Reset clears all written bits; array contents are not reset.
  - Entries whose written bit is clear never match.
- Match rule for entry e: written && ((e.vpn2 ^ key_vpn2) & mask(e.ps)) == 0 && (e.g || e.asid == key_asid).
  - mask = all ones for 4K; low 2 bits cleared for PS16K; low 4 bits cleared for PS64K.
- States: IDLE, SCAN, HOLD, MISS. Registers: key_vpn2, key_asid, grp (0..NGROUPS-1).
- IDLE: if p_valid && !w_valid, latch key, set grp=0, go to SCAN.
- SCAN, each cycle:
  - Compare entries grp*GROUP_SIZE .. grp*GROUP_SIZE+GROUP_SIZE-1 against the latched key.
  - On match: p_ready=1 in the same cycle (combinational from group compare), with p_index = lowest matching index and p_resp = that entry. Next state is HOLD.
  - No match, grp<NGROUPS-1: grp+1.
  - No match, grp==NGROUPS-1: go to MISS.
- Latency: a key latched at cycle T hits group k at cycle T+1+k; worst-case p_ready at T+NGROUPS. This is within the fast TLB's budget of NGROUPS+1 not-ready cycles before it declares a miss.
- HOLD / MISS: p_ready=0.
  - If p_valid and (p_ivpn2,p_iasid) differs from the latched key: relatch, grp=0, go to SCAN.
  - Otherwise stay.
  - MISS with an unchanged key stays silent, so the fast TLB times out and raises q_miss.
- Key change during SCAN (p_valid and input differs from the latched key): restart immediately; relatch, grp=0. The old key's result is never reported.
- p_valid low in any state: go to IDLE next cycle, p_ready=0.
- w_valid: array[w_index] and its written bit update at the edge.
  - FSM goes to IDLE; any in-flight scan is aborted and p_ready is forced 0 in that cycle.
  - Write has priority over probe in the same cycle.
- Multiple matches (architecturally undefined): lowest index wins; no machine-check signalled.
- Reset (including mid-scan): state IDLE, grp=0, p_ready=0. p_index and p_resp are don't-care when p_ready=0 (drive 0).
- All state updates occur on the rising clock edge; reset has priority over w_valid.

Test Plan:
- Hit in group 3: write vpn2=0x12345, asid=5, g=0, PS4K to index 13; probe (0x12345,5) at T -> p_ready only at T+4, p_index=13, p_resp equals the written entry.
- Full miss: probe (0x7FFFF,1) on a reset array -> p_ready never asserted over 32 cycles; FSM stays in MISS.
- Global/large page match: index 2 has g=1, PS16K, vpn2=0x00100; probe (0x00103, asid 9) -> hit at T+1, index 2. Probe 0x00104 -> miss.
- Duplicate match: same key written at indices 5 and 6 -> p_index=5.
- Abort by write: probe a key held only at index 60; assert w_valid at T+3 -> p_ready stays 0 that cycle.
  - Scan then restarts from group 0 (p_valid still high) and p_ready rises at T+4+1+15 = T+20 with index 60.
- Key change mid-scan and reset: change the key at T+2 -> result for the new key only. Assert reset at T+5 -> p_ready=0 next cycle; prior writes no longer match.

Source files
------------

// File: rtl/mips32r2_tlb_probe_engine.sv
// Joint TLB backing array with a group-serial probe engine.
// Serves fast-TLB refill probes and the CP0 TLBWI/TLBWR/TLBR ports.
package mips32r2_tlb_pkg;

  typedef enum logic [1:0] {
    PS4K  = 2'd0,
    PS16K = 2'd1,
    PS64K = 2'd2
  } tlb_ps_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_ps_e     ps;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLBEntry;

endpackage

module mips32r2_tlb_probe_engine
  import mips32r2_tlb_pkg::*;
#(
  parameter int ENTRIES    = 64,
  parameter int GROUP_SIZE = 4,
  localparam int IW        = $clog2(ENTRIES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p_valid,
  input  logic [18:0]           p_ivpn2,
  input  logic [7:0]            p_iasid,
  output logic                  p_ready,
  output logic [IW-1:0]         p_index,
  output logic [$bits(TLBEntry)-1:0] p_resp,
  input  logic                  w_valid,
  input  logic [IW-1:0]         w_index,
  input  logic [$bits(TLBEntry)-1:0] w_entry,
  input  logic [IW-1:0]         r_index,
  output logic [$bits(TLBEntry)-1:0] r_entry
);

  localparam int NGROUPS = ENTRIES / GROUP_SIZE;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int GSW     = $clog2(GROUP_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_HOLD,
    S_MISS
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [18:0]   r_key_vpn2;
  logic [18:0]   w_key_vpn2_nxt;
  logic [7:0]    r_key_asid;
  logic [7:0]    w_key_asid_nxt;
  logic [GW-1:0] r_grp;
  logic [GW-1:0] w_grp_nxt;

  TLBEntry          r_tlb [ENTRIES];
  logic [ENTRIES-1:0] r_written;

  logic          w_key_diff;
  logic          w_hit;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_sel;
  TLBEntry       w_sel_entry;

  // Large pages ignore the low VPN2 bits that fall inside the page.
  function automatic logic [18:0] f_mask(input tlb_ps_e ps);
    logic [18:0] m;
    m = '1;
    case (ps)
      PS16K:   m[1:0] = 2'b00;
      PS64K:   m[3:0] = 4'b0000;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic f_match(
    input TLBEntry     e,
    input logic        wr,
    input logic [18:0] vpn,
    input logic [7:0]  asid
  );
    return wr
      && (((e.vpn2 ^ vpn) & f_mask(e.ps)) == '0)
      && (e.g || (e.asid == asid));
  endfunction

  // Array contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (!reset && w_valid) begin
      r_tlb[w_index] <= TLBEntry'(w_entry);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_written <= '0;
    end else if (w_valid) begin
      r_written[w_index] <= 1'b1;
    end
  end

  assign r_entry = r_tlb[r_index];

  assign w_key_diff = (p_ivpn2 != r_key_vpn2)
                   || (p_iasid != r_key_asid);

  assign w_base = IW'(r_grp) << GSW;

  // Descending walk so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int g = GROUP_SIZE - 1; g >= 0; g--) begin
      if (f_match(r_tlb[w_base + IW'(g)],
                  r_written[w_base + IW'(g)],
                  r_key_vpn2, r_key_asid)) begin
        w_hit = 1'b1;
        w_sel = w_base + IW'(g);
      end
    end
  end

  assign w_sel_entry = r_tlb[w_sel];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grp      <= '0;
      r_key_vpn2 <= '0;
      r_key_asid <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grp      <= w_grp_nxt;
      r_key_vpn2 <= w_key_vpn2_nxt;
      r_key_asid <= w_key_asid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grp_nxt      = r_grp;
    w_key_vpn2_nxt = r_key_vpn2;
    w_key_asid_nxt = r_key_asid;
    if (w_valid || !p_valid) begin
      w_state_nxt = S_IDLE;
      w_grp_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_SCAN;
          w_grp_nxt      = '0;
          w_key_vpn2_nxt = p_ivpn2;
          w_key_asid_nxt = p_iasid;
        end
        S_SCAN: begin
          if (w_key_diff) begin
            w_grp_nxt      = '0;
            w_key_vpn2_nxt = p_ivpn2;
            w_key_asid_nxt = p_iasid;
          end else if (w_hit) begin
            w_state_nxt = S_HOLD;
          end else if (r_grp == GW'(NGROUPS - 1)) begin
            w_state_nxt = S_MISS;
          end else begin
            w_grp_nxt = r_grp + GW'(1);
          end
        end
        S_HOLD, S_MISS: begin
          if (w_key_diff) begin
            w_state_nxt    = S_SCAN;
            w_grp_nxt      = '0;
            w_key_vpn2_nxt = p_ivpn2;
            w_key_asid_nxt = p_iasid;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_grp_nxt   = '0;
        end
      endcase
    end
  end

  // A stale key or a concurrent write suppresses the hit pulse.
  always_comb begin
    p_ready = !reset
           && (r_state == S_SCAN)
           && p_valid
           && !w_valid
           && !w_key_diff
           && w_hit;
    p_index = '0;
    p_resp  = '0;
    if (p_ready) begin
      p_index = w_sel;
      p_resp  = w_sel_entry;
    end
  end

endmodule

// File: tb/tb_mips32r2_tlb_probe_engine.sv
// Directed bench for the joint TLB probe engine.
// Expected latencies and indices are hand-derived per vector.
module tb_mips32r2_tlb_probe_engine;
  import mips32r2_tlb_pkg::*;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          p_valid = 1'b0;
  logic [18:0]   p_ivpn2 = '0;
  logic [7:0]    p_iasid = '0;
  logic          p_ready;
  logic [5:0]    p_index;
  logic [$bits(TLBEntry)-1:0] p_resp;
  logic          w_valid = 1'b0;
  logic [5:0]    w_index = '0;
  logic [$bits(TLBEntry)-1:0] w_entry = '0;
  logic [5:0]    r_index = '0;
  logic [$bits(TLBEntry)-1:0] r_entry;

  int n_tot = 0;
  int n_bad = 0;

  mips32r2_tlb_probe_engine #(
    .ENTRIES   (64),
    .GROUP_SIZE(4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .p_valid(p_valid),
    .p_ivpn2(p_ivpn2),
    .p_iasid(p_iasid),
    .p_ready(p_ready),
    .p_index(p_index),
    .p_resp (p_resp),
    .w_valid(w_valid),
    .w_index(w_index),
    .w_entry(w_entry),
    .r_index(r_index),
    .r_entry(r_entry)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic TLBEntry mk(
    input logic [18:0] v,
    input logic [7:0]  a,
    input logic        g,
    input tlb_ps_e     ps
  );
    TLBEntry e;
    e      = '0;
    e.vpn2 = v;
    e.asid = a;
    e.g    = g;
    e.ps   = ps;
    e.pfn0 = {1'b0, v};
    e.pfn1 = {1'b1, v};
    e.c0   = 3'd3;
    e.c1   = 3'd2;
    e.d0   = 1'b1;
    e.v0   = 1'b1;
    e.v1   = 1'b1;
    return e;
  endfunction

  task automatic wr(input logic [5:0] idx, input TLBEntry e);
    w_valid = 1'b1;
    w_index = idx;
    w_entry = e;
    step();
    w_valid = 1'b0;
  endtask

  task automatic idle();
    p_valid = 1'b0;
    step();
  endtask

  // Drive a key at cycle T, then observe cycles T+1..T+maxc.
  task automatic probe(
    input  logic [18:0] vpn,
    input  logic [7:0]  asid,
    input  int          maxc,
    output int          lat,
    output int          np,
    output logic [5:0]  idx,
    output TLBEntry     resp
  );
    p_valid = 1'b1;
    p_ivpn2 = vpn;
    p_iasid = asid;
    lat  = -1;
    np   = 0;
    idx  = '0;
    resp = '0;
    for (int c = 1; c <= maxc; c++) begin
      step();
      @(negedge clock);
      if (p_ready) begin
        np++;
        if (lat < 0) begin
          lat  = c;
          idx  = p_index;
          resp = TLBEntry'(p_resp);
        end
      end
    end
  endtask

  TLBEntry    e13, e2, eb, ea, e60, e40, resp;
  int         lat, np, np_post;
  logic [5:0] idx;

  initial begin
    e13 = mk(19'h12345, 8'd5, 1'b0, PS4K);
    e2  = mk(19'h00100, 8'd0, 1'b1, PS16K);
    eb  = mk(19'h0AAAA, 8'd3, 1'b0, PS4K);
    ea  = mk(19'h01111, 8'd2, 1'b0, PS4K);
    e60 = mk(19'h55555, 8'd7, 1'b0, PS4K);
    e40 = mk(19'h33333, 8'd1, 1'b0, PS4K);

    step();
    step();
    @(negedge clock);
    check("rst_ready", p_ready, 0);
    check("rst_index", p_index, 0);
    check("rst_resp", p_resp, 0);
    reset = 1'b0;
    step();

    // Hit in group 3 at T+4
    wr(6'd13, e13);
    r_index = 6'd13;
    #1;
    check("tlbr_13", r_entry, e13);
    probe(19'h12345, 8'd5, 8, lat, np, idx, resp);
    check("g3_lat", lat, 4);
    check("g3_idx", idx, 13);
    check("g3_resp", resp, e13);
    check("g3_pulses", np, 1);
    idle();

    // Full miss on a cleared array
    reset = 1'b1;
    step();
    reset = 1'b0;
    probe(19'h7FFFF, 8'd1, 32, lat, np, idx, resp);
    check("miss_pulses", np, 0);
    idle();

    // Global 16K page: low two VPN2 bits ignored
    wr(6'd2, e2);
    probe(19'h00103, 8'd9, 3, lat, np, idx, resp);
    check("big_lat", lat, 1);
    check("big_idx", idx, 2);
    probe(19'h00104, 8'd9, 20, lat, np, idx, resp);
    check("big_out_pulses", np, 0);
    idle();

    // Duplicate key: lowest index wins
    wr(6'd5, eb);
    wr(6'd6, eb);
    probe(19'h0AAAA, 8'd3, 6, lat, np, idx, resp);
    check("dup_lat", lat, 2);
    check("dup_idx", idx, 5);
    idle();

    // Write at T+3 aborts the scan; restart gives T+20
    wr(6'd60, e60);
    p_valid = 1'b1;
    p_ivpn2 = 19'h55555;
    p_iasid = 8'd7;
    lat = -1;
    idx = '0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c == 3) begin
        w_valid = 1'b1;
        w_index = 6'd40;
        w_entry = e40;
      end
      if (c == 4) w_valid = 1'b0;
      @(negedge clock);
      if (c == 3) check("abort_cyc", p_ready, 0);
      if (p_ready && lat < 0) begin
        lat = c;
        idx = p_index;
      end
    end
    check("abort_lat", lat, 20);
    check("abort_idx", idx, 60);
    idle();

    // Key change at T+2, then reset at T+5
    wr(6'd9, ea);
    p_valid = 1'b1;
    p_ivpn2 = 19'h01111;
    p_iasid = 8'd2;
    lat = -1;
    np = 0;
    np_post = 0;
    idx = '0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 2) begin
        p_ivpn2 = 19'h0AAAA;
        p_iasid = 8'd3;
      end
      if (c == 5) reset = 1'b1;
      if (c == 6) reset = 1'b0;
      @(negedge clock);
      if (c == 6) check("rst_mid_ready", p_ready, 0);
      if (p_ready) begin
        np++;
        if (c >= 6) np_post++;
        if (lat < 0) begin
          lat = c;
          idx = p_index;
        end
      end
    end
    check("chg_lat", lat, 4);
    check("chg_idx", idx, 5);
    check("chg_pulses", np, 1);
    check("post_rst_pulses", np_post, 0);
    idle();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
